// File: rtl/hazard_scoreboard.sv
// Data-hazard and forwarding controller. Tracks in-flight register writers in a
// shift pipe (slot 0 = EX, slot NUM_STAGES-1 = WB), detects load-use hazards and
// selects the forwarding source for each ID operand.
module hazard_scoreboard #(
  parameter int unsigned NUM_STAGES       = 3,
  parameter int unsigned REG_AW           = 5,
  parameter int unsigned LOAD_AVAIL_STAGE = 1,
  parameter int unsigned CNT_W            = 16,
  localparam int unsigned SEL_W           = $clog2(NUM_STAGES + 1)
) (
  input  logic              clk,
  input  logic              R,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              id_use_c,
  input  logic              id_rf_le,
  input  logic              id_load,
  input  logic              id_flush,
  input  logic              mem_hold,
  input  logic              cnt_clr,
  output logic              le_if,
  output logic              nop_stall,
  output logic [SEL_W-1:0]  sel_a,
  output logic [SEL_W-1:0]  sel_b,
  output logic [SEL_W-1:0]  sel_c,
  output logic [CNT_W-1:0]  stall_count
);

  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [NUM_STAGES-1:0] ld_q, ld_d;
  logic [REG_AW-1:0]     rd_q [NUM_STAGES];
  logic [REG_AW-1:0]     rd_d [NUM_STAGES];
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [REG_AW-1:0] src    [3];
  logic [2:0]        use_v;
  logic [2:0]        hz_op;
  logic [SEL_W-1:0]  sel_op [3];
  logic              hazard;

  // Per-operand match: scan oldest to youngest so the youngest writer wins.
  always_comb begin
    src[0] = id_rs1;
    src[1] = id_rs2;
    src[2] = id_rd;
    use_v  = {id_use_c, id_use_b, id_use_a};
    for (int o = 0; o < 3; o++) begin
      hz_op[o]  = 1'b0;
      sel_op[o] = '0;
      for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
        if (use_v[o] && (src[o] != '0) && valid_q[i] && (rd_q[i] == src[o])) begin
          if (ld_q[i] && (i < int'(LOAD_AVAIL_STAGE))) begin
            // Load data not yet available: stall, read nothing forwarded.
            hz_op[o]  = 1'b1;
            sel_op[o] = '0;
          end else begin
            hz_op[o]  = 1'b0;
            sel_op[o] = SEL_W'(i + 1);
          end
        end
      end
    end
  end

  // Hazard and pipeline control outputs.
  always_comb begin
    hazard      = (|hz_op) & ~id_flush;
    le_if       = ~(hazard | mem_hold);
    nop_stall   = hazard | id_flush;
    sel_a       = sel_op[0];
    sel_b       = sel_op[1];
    sel_c       = sel_op[2];
    stall_count = cnt_q;
  end

  // Slot shift and stall-counter next state; a memory hold freezes the pipe.
  always_comb begin
    valid_d = valid_q;
    ld_d    = ld_q;
    rd_d    = rd_q;
    if (!mem_hold) begin
      for (int i = 1; i < int'(NUM_STAGES); i++) begin
        valid_d[i] = valid_q[i-1];
        ld_d[i]    = ld_q[i-1];
        rd_d[i]    = rd_q[i-1];
      end
      // r0 is never tracked; stalled or flushed instructions leave a bubble.
      valid_d[0] = id_rf_le & (id_rd != '0) & ~hazard & ~id_flush;
      ld_d[0]    = id_load;
      rd_d[0]    = id_rd;
    end

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hazard && !mem_hold && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      valid_q <= '0;
      ld_q    <= '0;
      rd_q    <= '{default: '0};
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ld_q    <= ld_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, hand sequences for hold,
// flush, mid-stall reset and counter saturation, then random stimulus against a
// queue-based reference model.
module tb_hazard_scoreboard;

  localparam int unsigned NS = 3;
  localparam int unsigned LA = 1;
  localparam int unsigned CW = 4;
  localparam int unsigned SW = 2;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk, R;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_use_a, id_use_b, id_use_c, id_rf_le, id_load, id_flush;
  logic          mem_hold, cnt_clr;
  logic          le_if, nop_stall;
  logic [SW-1:0] sel_a, sel_b, sel_c;
  logic [CW-1:0] stall_count;

  hazard_scoreboard #(
    .NUM_STAGES      (NS),
    .REG_AW          (5),
    .LOAD_AVAIL_STAGE(LA),
    .CNT_W           (CW)
  ) dut (
    .clk        (clk),
    .R          (R),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_use_a   (id_use_a),
    .id_use_b   (id_use_b),
    .id_use_c   (id_use_c),
    .id_rf_le   (id_rf_le),
    .id_load    (id_load),
    .id_flush   (id_flush),
    .mem_hold   (mem_hold),
    .cnt_clr    (cnt_clr),
    .le_if      (le_if),
    .nop_stall  (nop_stall),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .sel_c      (sel_c),
    .stall_count(stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       ua, ub, uc, rf_le, ld, flush, hold, clr;
  } in_t;

  typedef struct {
    in_t  i;
    logic le, nop;
    int   sa, sb, sc, cnt;
  } vec_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } ent_t;

  int   n_chk = 0;
  int   n_err = 0;
  vec_t tbl[$];
  ent_t pipe[$];
  int   m_cnt;

  function automatic in_t mk(input int rs1, input int rs2, input int rd, input bit ua,
                             input bit ub, input bit uc, input bit rf, input bit ld);
    in_t x;
    x = '0;
    x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.rd = 5'(rd);
    x.ua = ua; x.ub = ub; x.uc = uc; x.rf_le = rf; x.ld = ld;
    return x;
  endfunction

  task automatic add_vec(input in_t x, input logic le, input logic nop, input int sa,
                         input int sb, input int sc, input int cnt);
    vec_t v;
    v.i = x; v.le = le; v.nop = nop; v.sa = sa; v.sb = sb; v.sc = sc; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic apply(input in_t x);
    id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd;
    id_use_a = x.ua; id_use_b = x.ub; id_use_c = x.uc;
    id_rf_le = x.rf_le; id_load = x.ld; id_flush = x.flush;
    mem_hold = x.hold; cnt_clr = x.clr;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic le, input logic nop, input int sa,
                         input int sb, input int sc, input int cnt);
    chk({tag, " le_if"}, 32'(le_if), 32'(le));
    chk({tag, " nop_stall"}, 32'(nop_stall), 32'(nop));
    chk({tag, " sel_a"}, 32'(sel_a), 32'(sa));
    chk({tag, " sel_b"}, 32'(sel_b), 32'(sb));
    chk({tag, " sel_c"}, 32'(sel_c), 32'(sc));
    chk({tag, " stall_count"}, 32'(stall_count), 32'(cnt));
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: youngest in-flight writer of src, if any.
  task automatic m_match(input logic [4:0] src, input logic use_x, output logic hz,
                         output int sel);
    hz  = 1'b0;
    sel = 0;
    if (use_x && src != 0) begin
      for (int i = 0; i < pipe.size(); i++) begin
        if (pipe[i].v && pipe[i].rd == src) begin
          if (pipe[i].ld && i < int'(LA)) hz = 1'b1;
          else sel = i + 1;
          break;
        end
      end
    end
  endtask

  task automatic m_reset();
    ent_t e;
    e = '0;
    pipe.delete();
    for (int i = 0; i < int'(NS); i++) pipe.push_back(e);
    m_cnt = 0;
  endtask

  initial begin
    in_t  x;
    logic ha, hb, hc, hz, e_le, e_nop;
    int   sa, sb, sc;
    ent_t e;

    R = 1'b0;
    apply('0);
    #2;
    chk_all("reset", 1'b1, 1'b0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    R = 1'b1;

    // Directed table: each row is one ID cycle with its expected outputs.
    add_vec(mk(0, 0, 3, 0, 0, 0, 1, 0), 1, 0, 0, 0, 0, 0);  // add r3
    add_vec(mk(3, 0, 0, 1, 0, 0, 0, 0), 1, 0, 1, 0, 0, 0);
    add_vec(mk(3, 0, 0, 1, 0, 0, 0, 0), 1, 0, 2, 0, 0, 0);
    add_vec(mk(3, 0, 0, 1, 0, 0, 0, 0), 1, 0, 3, 0, 0, 0);
    add_vec(mk(3, 0, 0, 1, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0);
    add_vec(mk(0, 0, 5, 0, 0, 0, 1, 1), 1, 0, 0, 0, 0, 0);  // ld r5
    add_vec(mk(0, 5, 0, 0, 1, 0, 0, 0), 0, 1, 0, 0, 0, 0);  // load-use stall
    add_vec(mk(0, 5, 0, 0, 1, 0, 0, 0), 1, 0, 0, 2, 0, 1);
    add_vec(mk(0, 0, 4, 0, 0, 0, 1, 0), 1, 0, 0, 0, 0, 1);
    add_vec(mk(0, 0, 7, 0, 0, 0, 1, 0), 1, 0, 0, 0, 0, 1);
    add_vec(mk(0, 0, 4, 0, 0, 0, 1, 0), 1, 0, 0, 0, 0, 1);
    add_vec(mk(4, 7, 4, 1, 1, 0, 0, 0), 1, 0, 1, 2, 0, 1);  // youngest r4, use_c off
    add_vec(mk(7, 0, 0, 1, 1, 0, 1, 0), 1, 0, 3, 0, 0, 1);  // writes r0
    add_vec(mk(0, 4, 4, 1, 1, 1, 0, 0), 1, 0, 0, 3, 3, 1);
    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].i);
      @(negedge clk);
      chk_all($sformatf("vec%0d", k), tbl[k].le, tbl[k].nop, tbl[k].sa, tbl[k].sb,
              tbl[k].sc, tbl[k].cnt);
      next_cyc();
    end

    // Memory hold: slots frozen, ID writes ignored even when flushed.
    apply(mk(0, 0, 3, 0, 0, 0, 1, 0));
    @(negedge clk);
    chk("hold_pre le_if", 32'(le_if), 32'd1);
    next_cyc();
    for (int k = 0; k < 3; k++) begin
      x = mk(3, 0, 9, 1, 0, 0, 1, 0);
      x.hold  = 1'b1;
      x.flush = (k == 1);
      apply(x);
      @(negedge clk);
      chk_all($sformatf("hold%0d", k), 1'b0, x.flush, 1, 0, 0, 1);
      next_cyc();
    end
    apply(mk(3, 0, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    chk_all("hold_rel", 1'b1, 1'b0, 1, 0, 0, 1);
    next_cyc();
    @(negedge clk);
    chk_all("hold_adv", 1'b1, 1'b0, 2, 0, 0, 1);
    next_cyc();

    // Flush during a load-use: bubble, no count, flushed writer not tracked.
    apply(mk(0, 0, 6, 0, 0, 0, 1, 1));
    @(negedge clk);
    chk_all("flush_ld", 1'b1, 1'b0, 0, 0, 0, 1);
    next_cyc();
    x = mk(6, 0, 6, 1, 0, 0, 1, 0);
    x.flush = 1'b1;
    apply(x);
    @(negedge clk);
    chk_all("flush_lu", 1'b1, 1'b1, 0, 0, 0, 1);
    next_cyc();
    apply(mk(6, 0, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    chk_all("flush_post", 1'b1, 1'b0, 2, 0, 0, 1);
    next_cyc();

    // Asynchronous reset in the middle of a load-use stall.
    apply(mk(0, 0, 2, 0, 0, 0, 1, 1));
    next_cyc();
    apply(mk(2, 0, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    chk_all("rst_pre", 1'b0, 1'b1, 0, 0, 0, 1);
    R = 1'b0;
    #1;
    chk_all("rst_mid", 1'b1, 1'b0, 0, 0, 0, 0);
    next_cyc();
    R = 1'b1;
    @(negedge clk);
    chk_all("rst_post", 1'b1, 1'b0, 0, 0, 0, 0);
    next_cyc();

    // Saturation: back-to-back dependent loads stall every other cycle.
    x = mk(5, 0, 5, 1, 0, 0, 1, 1);
    for (int k = 0; k < 40; k++) begin
      apply(x);
      if (k == 10) begin
        @(negedge clk);
        chk("sat_mid stall_count", 32'(stall_count), 32'd5);
      end
      next_cyc();
    end
    apply(x);
    @(negedge clk);
    chk("sat_full stall_count", 32'(stall_count), 32'(CNT_MAX));
    chk("sat_full le_if", 32'(le_if), 32'd1);
    next_cyc();
    x.clr = 1'b1;
    apply(x);
    @(negedge clk);
    chk("sat_clr le_if", 32'(le_if), 32'd0);
    chk("sat_clr stall_count", 32'(stall_count), 32'(CNT_MAX));
    next_cyc();
    apply('0);
    @(negedge clk);
    chk("sat_after_clr stall_count", 32'(stall_count), 32'd0);
    next_cyc();

    // Random stimulus against the reference model.
    R = 1'b0;
    #1;
    m_reset();
    next_cyc();
    R = 1'b1;
    for (int n = 0; n < 500; n++) begin
      x.rs1   = 5'($urandom_range(0, 7));
      x.rs2   = 5'($urandom_range(0, 7));
      x.rd    = 5'($urandom_range(0, 7));
      x.ua    = 1'($urandom_range(0, 1));
      x.ub    = 1'($urandom_range(0, 1));
      x.uc    = 1'($urandom_range(0, 1));
      x.rf_le = ($urandom_range(0, 9) < 7);
      x.ld    = ($urandom_range(0, 9) < 4);
      x.flush = ($urandom_range(0, 9) == 0);
      x.hold  = ($urandom_range(0, 19) < 3);
      x.clr   = ($urandom_range(0, 39) == 0);
      apply(x);
      m_match(x.rs1, x.ua, ha, sa);
      m_match(x.rs2, x.ub, hb, sb);
      m_match(x.rd, x.uc, hc, sc);
      hz    = (ha | hb | hc) & ~x.flush;
      e_le  = ~(hz | x.hold);
      e_nop = hz | x.flush;
      @(negedge clk);
      chk_all($sformatf("rnd%0d", n), e_le, e_nop, sa, sb, sc, m_cnt);
      @(posedge clk);
      if (!x.hold) begin
        e.v  = x.rf_le && (x.rd != 0) && !hz && !x.flush;
        e.rd = x.rd;
        e.ld = x.ld;
        pipe.push_front(e);
        pipe.delete(pipe.size() - 1);
      end
      if (x.clr) m_cnt = 0;
      else if (hz && !x.hold && m_cnt < CNT_MAX) m_cnt++;
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
